// File: rtl/ps2m_pkg.sv
// Shared types and constants for the PS/2 mouse receiver.
package ps2m_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned SYNC_BIT   = 3;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned MOUSE_W    = 25;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } frame_state_e;

  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    B2 = 2'd2
  } pkt_state_e;

  // Mouse bus payload as seen by the register front ends.
  typedef struct packed {
    logic              toggle;
    logic [BYTE_W-1:0] dy;
    logic [BYTE_W-1:0] dx;
    logic [BYTE_W-1:0] status;
  } ps2_mouse_t;

  // Odd parity: data plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [BYTE_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, 11-bit frame
// FSM and mid-frame bit timeout. Outputs are single-cycle combinational strobes.
module ps2_frame_rx
  import ps2m_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned BIT_TIMEOUT = 100000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ps2_clk,
  input  logic              ps2_dat,
  output logic              byte_valid_c,
  output logic [BYTE_W-1:0] byte_c,
  output logic              frame_err_c
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(BIT_TIMEOUT + 1);
  localparam int unsigned CW = 4;

  logic [1:0]    clk_sync_q;
  logic [1:0]    dat_sync_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_c;
  logic          dat_s;

  frame_state_e  state_q, state_d;
  logic [CW-1:0] bitcnt_q, bitcnt_d;
  logic [BYTE_W:0] shift_q, shift_d;
  logic [TW-1:0] idle_cnt_q, idle_cnt_d;

  assign dat_s = dat_sync_q[1];

  // Two-flop synchronisers; idle-high reset so no edge is seen out of reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
    end
  end

  // Filtered clock level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall_c = filt_q & ~filt_d;

  // Filter state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Frame FSM next state: start check, LSB-first shift, parity/stop check, timeout.
  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    idle_cnt_d   = idle_cnt_q;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    byte_c       = shift_q[BYTE_W-1:0];
    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (fall_c) begin
          if (!dat_s) begin
            state_d  = SHIFT;
            bitcnt_d = CW'(1);
          end else begin
            frame_err_c = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (fall_c) begin
          idle_cnt_d = '0;
          if (bitcnt_q == CW'(FRAME_BITS - 1)) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            if (odd_parity_ok(shift_q[BYTE_W-1:0], shift_q[BYTE_W]) && dat_s) begin
              byte_valid_c = 1'b1;
            end else begin
              frame_err_c = 1'b1;
            end
          end else begin
            shift_d  = {dat_s, shift_q[BYTE_W:1]};
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else if (idle_cnt_q == TW'(BIT_TIMEOUT - 1)) begin
          frame_err_c = 1'b1;
          state_d     = IDLE;
          bitcnt_d    = '0;
          idle_cnt_d  = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Frame FSM state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: assembles 3-byte movement packets and publishes
// them on the 25-bit mouse bus by flipping the toggle bit.
// Optional PS2M_ERRCNT_EN adds a saturating 8-bit frame error counter on err_cnt.
module ps2_mouse_rx
  import ps2m_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned BIT_TIMEOUT = 100000,
  parameter int unsigned PKT_TIMEOUT = 1000000
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  output logic [MOUSE_W-1:0] ps2_mouse,
  output logic               frame_err
`ifdef PS2M_ERRCNT_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  localparam int unsigned GW = $clog2(PKT_TIMEOUT + 1);

  logic              byte_valid_c;
  logic [BYTE_W-1:0] byte_c;
  logic              rx_err_c;

  pkt_state_e        pstate_q, pstate_d;
  logic [BYTE_W-1:0] status_q, status_d;
  logic [BYTE_W-1:0] dx_q, dx_d;
  logic [GW-1:0]     gap_q, gap_d;
  ps2_mouse_t        mouse_q, mouse_d;
  logic              frame_err_q, frame_err_d;

  ps2_frame_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .BIT_TIMEOUT (BIT_TIMEOUT)
  ) u_frame_rx (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .byte_valid_c (byte_valid_c),
    .byte_c       (byte_c),
    .frame_err_c  (rx_err_c)
  );

  // Packet FSM next state: sync-bit alignment, byte capture, publish, gap timeout.
  always_comb begin
    pstate_d    = pstate_q;
    status_d    = status_q;
    dx_d        = dx_q;
    gap_d       = '0;
    mouse_d     = mouse_q;
    frame_err_d = rx_err_c;
    case (pstate_q)
      B0: begin
        if (byte_valid_c && byte_c[SYNC_BIT]) begin
          status_d = byte_c;
          pstate_d = B1;
        end
      end
      B1: begin
        if (byte_valid_c) begin
          dx_d     = byte_c;
          pstate_d = B2;
        end else if (rx_err_c) begin
          pstate_d = B0;
        end else if (gap_q == GW'(PKT_TIMEOUT - 1)) begin
          pstate_d    = B0;
          frame_err_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      B2: begin
        if (byte_valid_c) begin
          mouse_d.toggle = ~mouse_q.toggle;
          mouse_d.dy     = byte_c;
          mouse_d.dx     = dx_q;
          mouse_d.status = status_q;
          pstate_d       = B0;
        end else if (rx_err_c) begin
          pstate_d = B0;
        end else if (gap_q == GW'(PKT_TIMEOUT - 1)) begin
          pstate_d    = B0;
          frame_err_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: pstate_d = B0;
    endcase
  end

  // Packet FSM state, captured bytes and registered outputs.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pstate_q    <= B0;
      status_q    <= '0;
      dx_q        <= '0;
      gap_q       <= '0;
      mouse_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      pstate_q    <= pstate_d;
      status_q    <= status_d;
      dx_q        <= dx_d;
      gap_q       <= gap_d;
      mouse_q     <= mouse_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign ps2_mouse = mouse_q;
  assign frame_err = frame_err_q;

`ifdef PS2M_ERRCNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of frame error pulses, cleared only by reset.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Directed bench for ps2_mouse_rx with shortened timeouts.
module tb_ps2_mouse_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned BT   = 400;
  localparam int unsigned PT   = 3000;
  localparam int unsigned HALF = 20;

  logic        clk_sys;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_dat;
  logic [24:0] ps2_mouse;
  logic        frame_err;
`ifdef PS2M_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int n_checks;
  int n_fail;
  int err_pulses;
  int err_base;

  ps2_mouse_rx #(
    .FILTER_LEN  (FILT),
    .BIT_TIMEOUT (BT),
    .PKT_TIMEOUT (PT)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .ps2_mouse (ps2_mouse),
    .frame_err (frame_err)
`ifdef PS2M_ERRCNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Count frame_err pulses away from the active edge.
  always @(negedge clk_sys) begin
    if (reset_n && frame_err === 1'b1) err_pulses++;
  end

  task automatic check(input string tag, input logic [24:0] obs, input logic [24:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par);
    logic par;
    par = (~^d) ^ bad_par;
    return {1'b1, par, d, 1'b0};
  endfunction

  // Drive frame bits first..last; optional clock glitch before bit glitch_at,
  // optional abort with clock held high after bit stall_at.
  task automatic drive_bits(input logic [10:0] f, input int first, input int last,
                            input int glitch_at, input int stall_at);
    for (int i = first; i <= last; i++) begin
      ps2_dat = f[i];
      if (i == glitch_at) begin
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(FILT - 2);
        ps2_clk = 1'b1;
      end
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
      if (i == stall_at) begin
        wait_cyc(BT + 20);
        ps2_dat = 1'b1;
        return;
      end
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par);
    drive_bits(mk_frame(d, bad_par), 0, 10, -1, -1);
    wait_cyc(2 * HALF);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b0);
    send_byte(b1, 1'b0);
    send_byte(b2, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    err_pulses = 0;
    ps2_clk    = 1'b1;
    ps2_dat    = 1'b1;
    reset_n    = 1'b0;
    wait_cyc(5);
    reset_n = 1'b1;
    wait_cyc(5);

    // Reset state.
    check("reset_mouse", ps2_mouse, 25'h0);
    check("reset_ferr", 25'(frame_err), 25'h0);
`ifdef PS2M_ERRCNT_EN
    check("reset_errcnt", 25'(err_cnt), 25'h0);
`endif

    // First packet; bus must not move before the third byte.
    err_base = err_pulses;
    send_byte(8'h09, 1'b0);
    check("p1_after_b0", ps2_mouse, 25'h0);
    send_byte(8'h05, 1'b0);
    check("p1_after_b1", ps2_mouse, 25'h0);
    send_byte(8'hFE, 1'b0);
    check("p1_publish", ps2_mouse, 25'h1FE0509);
    check("p1_no_err", 25'(err_pulses - err_base), 25'd0);

    // Second packet toggles bit 24 back to 0.
    send_pkt(8'h08, 8'h00, 8'h00);
    check("p2_publish", ps2_mouse, 25'h0000008);

    // Parity error on the dx byte aborts the packet.
    err_base = err_pulses;
    send_byte(8'h09, 1'b0);
    send_byte(8'h05, 1'b1);
    check("par_no_update", ps2_mouse, 25'h0000008);
    check("par_one_err", 25'(err_pulses - err_base), 25'd1);
`ifdef PS2M_ERRCNT_EN
    check("par_errcnt", 25'(err_cnt), 25'd1);
`endif
    send_pkt(8'h09, 8'h05, 8'hFE);
    check("par_recover", ps2_mouse, 25'h1FE0509);

    // Leading byte without sync bit is dropped silently.
    err_base = err_pulses;
    send_byte(8'h05, 1'b0);
    send_pkt(8'h18, 8'h10, 8'h20);
    check("resync_publish", ps2_mouse, 25'h0201018);
    check("resync_no_err", 25'(err_pulses - err_base), 25'd0);

    // Clock glitch ignored; stall after bit 4 aborts the frame.
    err_base = err_pulses;
    drive_bits(mk_frame(8'h09, 1'b0), 0, 10, 3, -1);
    wait_cyc(2 * HALF);
    drive_bits(mk_frame(8'h00, 1'b0), 0, 10, -1, 4);
    wait_cyc(2 * HALF);
    check("stall_no_update", ps2_mouse, 25'h0201018);
    check("stall_one_err", 25'(err_pulses - err_base), 25'd1);
    send_pkt(8'h08, 8'h7F, 8'h80);
    check("stall_recover", ps2_mouse, 25'h1807F08);

    // Packet gap timeout after the status byte restarts assembly.
    err_base = err_pulses;
    send_byte(8'h08, 1'b0);
    wait_cyc(PT + 100);
    check("gap_one_err", 25'(err_pulses - err_base), 25'd1);
    check("gap_no_update", ps2_mouse, 25'h1807F08);
`ifdef PS2M_ERRCNT_EN
    check("gap_errcnt", 25'(err_cnt), 25'd3);
`endif
    send_pkt(8'h09, 8'h01, 8'h02);
    check("gap_recover", ps2_mouse, 25'h0020109);

    // Asynchronous reset in the middle of the third byte.
    send_byte(8'h09, 1'b0);
    send_byte(8'h05, 1'b0);
    drive_bits(mk_frame(8'hFE, 1'b0), 0, 4, -1, -1);
    wait_cyc(5);
    #2 reset_n = 1'b0;
    #1 check("async_reset", ps2_mouse, 25'h0);
    wait_cyc(3);
    reset_n = 1'b1;
    drive_bits(mk_frame(8'hFE, 1'b0), 5, 10, -1, -1);
    wait_cyc(BT + 100);
    check("reset_tail_no_pub", ps2_mouse, 25'h0);
    send_pkt(8'h08, 8'h11, 8'h22);
    check("reset_recover", ps2_mouse, 25'h1221108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_rx.md
Name: ps2_mouse_rx

Overview:
- Receives a live PS/2 mouse serial stream and produces the 25-bit `ps2_mouse` bus that the mouse-register blocks consume.
- Bus format: {toggle, dy[7:0], dx[7:0], status[7:0]}.
- Deserialises 11-bit PS/2 frames and assembles standard 3-byte movement packets.
- Publishes each complete, valid packet atomically by flipping the toggle bit (bit 24).
- Sits between the board-level PS/2 pins and any multiplay/AMX-style mouse register front end.

Parameters:
- FILTER_LEN, 8: clk_sys cycles ps2_clk must hold a new level before it is accepted (glitch filter).
- BIT_TIMEOUT, 100000: clk_sys cycles without a falling edge mid-frame before the frame is aborted.
- PKT_TIMEOUT, 1000000: clk_sys cycles allowed between bytes of one packet before packet assembly restarts.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- ps2_mouse  out  25  {toggle, dy, dx, status}.
- frame_err  out  1  one-cycle pulse on parity, start, stop or timeout error.
- err_cnt  out  8  present only with PS2M_ERRCNT_EN; see Optional Feature.

Behaviour:
- Reset: one clock, asynchronous and active-low (`reset_n` asserted low clears state immediately, independent of `clk_sys`).
  - ps2_mouse=0, frame_err=0, err_cnt=0.
  - Both FSMs idle; counters cleared.
  - Reset mid-frame or mid-packet discards all partial data; no publish.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - ps2_clk then goes through a filter counter: the filtered level changes only after FILTER_LEN consecutive equal samples.
  - Falling edge = filtered level going 1->0.
  - ps2_dat is sampled in the cycle the falling edge is detected.
- Frame FSM (IDLE, SHIFT):
  - IDLE: on a falling edge, sample the start bit. If 0, go to SHIFT with bitcnt=1; if 1, pulse frame_err and stay in IDLE.
  - SHIFT: each falling edge shifts ps2_dat in (bits 1..8 = data LSB first, 9 = parity, 10 = stop) and increments bitcnt.
  - At bitcnt 10: check odd parity over data+parity and stop==1.
    - Pass: byte_valid strobe, one cycle, with byte[7:0].
    - Fail: frame_err pulse.
    - Either way, return to IDLE.
  - Idle counter reloads on every falling edge. If it reaches BIT_TIMEOUT while in SHIFT: frame_err pulse, go to IDLE.
- Packet FSM (B0, B1, B2):
  - B0: accept a byte only if bit3==1 (PS/2 sync bit); store as status, go to B1. Otherwise silently discard (resync, no frame_err).
  - B1: store dx, go to B2.
  - B2: store dy, then publish in the same cycle.
    - Publish: ps2_mouse <= {~ps2_mouse[24], dy, dx, status}, go to B0.
  - Any frame_err while in B1/B2: return to B0, no publish.
  - Gap timer runs in B1/B2, cleared on each byte_valid. Reaching PKT_TIMEOUT: return to B0 and pulse frame_err.
- Latency: publish occurs 1 cycle after the stop-bit falling edge is detected.
- Simultaneous events:
  - Timeout and falling edge in the same cycle: the edge wins, and the counter reloads.
  - Packet timeout and byte_valid in the same cycle: the byte is processed and the timer cleared.
- Bits [23:0] of ps2_mouse change only in the publish cycle, together with bit 24.
- Direction bits status[4]/[5] and overflow bits [6]/[7] pass through unmodified; consumers sign-extend.

Optional Feature:
- Macro: PS2M_ERRCNT_EN.
- Defined:
  - err_cnt port exists.
  - 8-bit counter increments on each frame_err pulse and saturates at 8'hFF.
  - Cleared only by reset_n.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package ps2m_pkg:
  - FRAME_BITS=11, SYNC_BIT=3.
  - Frame-state enum {IDLE, SHIFT}.
  - Packet-state enum {B0, B1, B2}.
- Sub-module ps2_frame_rx owns the synchronisers, filter, frame FSM and bit timeout. Outputs: byte_valid, byte, frame_err.
- Top level holds the packet FSM, gap timer, output register and optional counter.

Test Plan:
- Valid packet 0x09, 0x05, 0xFE after reset -> ps2_mouse = {1'b1, 8'hFE, 8'h05, 8'h09}; frame_err never asserted.
- Second packet 0x08, 0x00, 0x00 -> bit24 returns to 0, ps2_mouse = 25'h0000008.
- Wrong parity on byte 1 of 0x09/0x05/0xFE -> one frame_err pulse, no update; a following valid packet publishes correctly (err_cnt=1 if enabled).
- Leading byte 0x05 (bit3=0), then 0x18, 0x10, 0x20 -> 0x05 dropped without frame_err; publish {~t, 8'h20, 8'h10, 8'h18}.
- ps2_clk glitch low for FILTER_LEN-2 cycles mid-frame, and a stall of BIT_TIMEOUT+1 cycles after bit 4 -> glitch ignored; stall gives frame_err, FSM back in IDLE, next packet is received.
- reset_n pulsed low during byte 2 -> immediate clear, ps2_mouse=0; the remainder of the interrupted frame produces no publish; the next full packet publishes.
